fp_addsub_pipe: RTL

//   Elastic two-stage issue/writeback wrapper for the FPU's combinational single-precision adder.
//   - Upstream: accepts FADD.S/FSUB.S operands from the core over a valid/ready handshake.
//   - Towards the adder: conditions the operands (FSUB sign flip, optional flush-to-zero) and

---
 rtl/fp_addsub_pipe.sv | 98 +++++++++
 1 files changed

// File: rtl/fp_addsub_pipe.sv
// rtl/fp_addsub_pipe.sv - elastic two-stage issue/writeback wrapper around a combinational FP adder
`timescale 1ns/1ps
module fp_addsub_pipe #(
    parameter int RD_W = 5,
    parameter int FTZ  = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            in_sub,
    input  logic [31:0]     in_a,
    input  logic [31:0]     in_b,
    input  logic [RD_W-1:0] in_rd,
    input  logic            flush,
    output logic [31:0]     add_a,
    output logic [31:0]     add_b,
    input  logic [31:0]     add_res,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_res,
    output logic [RD_W-1:0] out_rd,
    input  logic [RD_W-1:0] chk_rs1,
    input  logic [RD_W-1:0] chk_rs2,
    output logic            chk_hit,
    output logic            busy
);

    logic            s1_v;
    logic            s2_v;
    logic [31:0]     s1_a;
    logic [31:0]     s1_b;
    logic [31:0]     s2_res;
    logic [RD_W-1:0] s1_rd;
    logic [RD_W-1:0] s2_rd;
    logic            s2_adv;
    logic            s1_adv;
    logic            accept;

    // Subnormals collapse to a signed zero when flush-to-zero is enabled; NaN/Inf untouched.
    function automatic logic [31:0] cond(input logic [31:0] x);
        if (FTZ != 0 && x[30:23] == 8'd0)
            return {x[31], 31'b0};
        return x;
    endfunction

    assign s2_adv   = !s2_v || out_ready;
    assign s1_adv   = s1_v && s2_adv;
    assign in_ready = (!s1_v || s2_adv) && !flush;
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v   <= 1'b0;
            s2_v   <= 1'b0;
            s1_a   <= '0;
            s1_b   <= '0;
            s1_rd  <= '0;
            s2_res <= '0;
            s2_rd  <= '0;
        end else begin
            if (flush) begin
                s1_v <= 1'b0;
                s2_v <= 1'b0;
            end else begin
                if (accept)
                    s1_v <= 1'b1;
                else if (s1_adv)
                    s1_v <= 1'b0;
                if (s1_adv)
                    s2_v <= 1'b1;
                else if (out_ready)
                    s2_v <= 1'b0;
            end
            if (accept) begin
                s1_a  <= cond(in_a);
                s1_b  <= cond({in_b[31] ^ in_sub, in_b[30:0]});
                s1_rd <= in_rd;
            end
            if (s1_adv) begin
                s2_res <= add_res;
                s2_rd  <= s1_rd;
            end
        end
    end

    assign add_a     = s1_a;
    assign add_b     = s1_b;
    assign out_valid = s2_v;
    assign out_res   = s2_res;
    assign out_rd    = s2_rd;
    assign busy      = s1_v || s2_v;

    // Register f0 is real, so tag zero is compared like any other.
    assign chk_hit = (s1_v && (s1_rd == chk_rs1)) || (s2_v && (s2_rd == chk_rs1)) ||
                     (s1_v && (s1_rd == chk_rs2)) || (s2_v && (s2_rd == chk_rs2));

endmodule
